// File: rtl/vexec_seq_pkg.sv
// Shared types for the vector execute sequencer: the FSM state encoding
// and the bundle of Execute control bits carried unchanged on every beat.
package vexec_seq_pkg;

  localparam int ALU_CTRL_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } vexec_state_t;

  typedef struct packed {
    logic [ALU_CTRL_W-1:0] aluControl;
    logic                  useInmediate;
    logic                  useScalarAlu;
    logic                  isScalarReg2;
  } exec_ctrl_t;

endpackage

// File: rtl/lane_mask_gen.sv
// Lane-valid mask for one Execute beat. Scalar ops use lane 0 only; the
// final beat of a vector op with a partial tail enables only the low
// 'rem' lanes; every other beat enables all lanes.
module lane_mask_gen #(
  parameter int VECTOR_SIZE = 8,
  parameter int REM_W       = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
  input  logic [REM_W-1:0]       rem_i,
  input  logic                   is_last_i,
  input  logic                   is_scalar_i,
  output logic [VECTOR_SIZE-1:0] lane_mask_o
);

  // Select full, tail-partial or scalar-only mask
  always_comb begin
    lane_mask_o = '1;
    if (is_scalar_i) begin
      lane_mask_o = VECTOR_SIZE'(1);
    end else if (is_last_i && (rem_i != '0)) begin
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        lane_mask_o[i] = (i < int'(rem_i));
      end
    end
  end

endmodule

// File: rtl/vector_exec_sequencer.sv
// Strip-mining controller between issue and Execute. One accepted request
// is replayed to Execute as ceil(vlen/VECTOR_SIZE) beats (one beat for
// scalar ops), each carrying a chunk index, a lane mask and the latched
// control bits. Owns no datapath.
//
// Optional feature: define VEXEC_SEQ_PERF_EN to build the 32-bit beat and
// stall performance counters; otherwise perf_beats/perf_stalls read 0.
module vector_exec_sequencer
  import vexec_seq_pkg::*;
#(
  parameter int VECTOR_SIZE = 8,
  parameter int LEN_W       = 8,
  parameter int IDX_W       = LEN_W - $clog2(VECTOR_SIZE) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ALU_CTRL_W-1:0]  req_aluControl,
  input  logic                   req_useInmediate,
  input  logic                   req_useScalarAlu,
  input  logic                   req_isScalarReg2,
  input  logic [LEN_W-1:0]       req_vlen,
  output logic                   exe_valid,
  input  logic                   exe_ready,
  output logic [ALU_CTRL_W-1:0]  aluControl,
  output logic                   useInmediate,
  output logic                   useScalarAlu,
  output logic                   isScalarReg2,
  output logic [IDX_W-1:0]       chunk_idx,
  output logic [VECTOR_SIZE-1:0] lane_mask,
  output logic                   first,
  output logic                   last,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            perf_beats,
  output logic [31:0]            perf_stalls
);

  localparam int SH    = $clog2(VECTOR_SIZE);
  localparam int REM_W = (VECTOR_SIZE > 1) ? SH : 1;

  vexec_state_t     state_q;
  exec_ctrl_t       ctrl_q;
  logic [IDX_W-1:0] cnt_q;
  logic [IDX_W-1:0] last_idx_q;
  logic [REM_W-1:0] rem_q;
  logic             done_q;
  logic             alive_q;

  exec_ctrl_t       ctrl_d;
  logic [LEN_W:0]   vlen_ceil_d;
  logic [LEN_W:0]   nbeats_raw_d;
  logic [IDX_W-1:0] nbeats_d;
  logic [REM_W-1:0] rem_d;

  logic in_issue;
  logic req_fire;
  logic beat_fire;
  logic on_last;
  logic [VECTOR_SIZE-1:0] mask_raw;

  // Request-side decode: beat count rounded up, scalar ops forced to one beat
  assign ctrl_d       = '{aluControl:   req_aluControl,
                          useInmediate: req_useInmediate,
                          useScalarAlu: req_useScalarAlu,
                          isScalarReg2: req_isScalarReg2};
  assign vlen_ceil_d  = {1'b0, req_vlen} + (LEN_W+1)'(VECTOR_SIZE - 1);
  assign nbeats_raw_d = vlen_ceil_d >> SH;
  assign nbeats_d     = req_useScalarAlu ? IDX_W'(1) : IDX_W'(nbeats_raw_d);
  assign rem_d        = req_vlen[REM_W-1:0];

  // alive_q keeps req_ready low while reset is held and for the release cycle
  assign in_issue  = (state_q == ISSUE);
  assign req_ready = alive_q && !in_issue && !flush;
  assign req_fire  = req_valid && req_ready;
  assign beat_fire = in_issue && exe_ready;
  assign on_last   = (cnt_q == last_idx_q);

  // Sequencer FSM: accept in IDLE, step through beats in ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ctrl_q     <= '0;
      cnt_q      <= '0;
      last_idx_q <= '0;
      rem_q      <= '0;
      done_q     <= 1'b0;
      alive_q    <= 1'b0;
    end else begin
      alive_q <= 1'b1;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            ctrl_q     <= ctrl_d;
            cnt_q      <= '0;
            rem_q      <= rem_d;
            last_idx_q <= nbeats_d - IDX_W'(1);
            if (nbeats_d == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flush) begin
            state_q <= IDLE;
          end else if (exe_ready) begin
            cnt_q <= cnt_q + IDX_W'(1);
            if (on_last) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  lane_mask_gen #(
    .VECTOR_SIZE (VECTOR_SIZE),
    .REM_W       (REM_W)
  ) u_lane_mask_gen (
    .rem_i       (rem_q),
    .is_last_i   (on_last),
    .is_scalar_i (ctrl_q.useScalarAlu),
    .lane_mask_o (mask_raw)
  );

  // Beat outputs are decoded from registered state and zero outside ISSUE
  assign exe_valid    = in_issue;
  assign busy         = in_issue;
  assign done         = done_q;
  assign chunk_idx    = in_issue ? cnt_q : '0;
  assign lane_mask    = in_issue ? mask_raw : '0;
  assign first        = in_issue && (cnt_q == '0);
  assign last         = in_issue && on_last;
  assign aluControl   = ctrl_q.aluControl;
  assign useInmediate = ctrl_q.useInmediate;
  assign useScalarAlu = ctrl_q.useScalarAlu;
  assign isScalarReg2 = ctrl_q.isScalarReg2;

`ifdef VEXEC_SEQ_PERF_EN
  logic [31:0] perf_beats_q;
  logic [31:0] perf_stalls_q;

  // Free-running counters; only rst_n clears them, flush does not
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_beats_q  <= '0;
      perf_stalls_q <= '0;
    end else begin
      if (beat_fire) begin
        perf_beats_q <= perf_beats_q + 32'd1;
      end
      if (in_issue && !exe_ready) begin
        perf_stalls_q <= perf_stalls_q + 32'd1;
      end
    end
  end

  assign perf_beats  = perf_beats_q;
  assign perf_stalls = perf_stalls_q;
`else
  assign perf_beats  = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_vector_exec_sequencer.sv
// Scoreboard bench for vector_exec_sequencer: the driver pushes the beats a
// request should produce, a monitor pops and compares on every handshake
// and tracks the expected done pulses.
module tb_vector_exec_sequencer;

  localparam int VS    = 8;
  localparam int LEN_W = 8;
  localparam int IDX_W = 6;

  typedef struct packed {
    logic [3:0]       alu;
    logic             imm;
    logic             sc;
    logic             sr2;
    logic [IDX_W-1:0] idx;
    logic [VS-1:0]    mask;
    logic             first;
    logic             last;
  } beat_t;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_aluControl;
  logic             req_useInmediate;
  logic             req_useScalarAlu;
  logic             req_isScalarReg2;
  logic [LEN_W-1:0] req_vlen;
  logic             exe_valid;
  logic             exe_ready;
  logic [3:0]       aluControl;
  logic             useInmediate;
  logic             useScalarAlu;
  logic             isScalarReg2;
  logic [IDX_W-1:0] chunk_idx;
  logic [VS-1:0]    lane_mask;
  logic             first;
  logic             last;
  logic             busy;
  logic             done;
  logic [31:0]      perf_beats;
  logic [31:0]      perf_stalls;

  logic rand_en;
  logic ready_force;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  vector_exec_sequencer #(
    .VECTOR_SIZE (VS),
    .LEN_W       (LEN_W),
    .IDX_W       (IDX_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_aluControl   (req_aluControl),
    .req_useInmediate (req_useInmediate),
    .req_useScalarAlu (req_useScalarAlu),
    .req_isScalarReg2 (req_isScalarReg2),
    .req_vlen         (req_vlen),
    .exe_valid        (exe_valid),
    .exe_ready        (exe_ready),
    .aluControl       (aluControl),
    .useInmediate     (useInmediate),
    .useScalarAlu     (useScalarAlu),
    .isScalarReg2     (isScalarReg2),
    .chunk_idx        (chunk_idx),
    .lane_mask        (lane_mask),
    .first            (first),
    .last             (last),
    .busy             (busy),
    .done             (done),
    .perf_beats       (perf_beats),
    .perf_stalls      (perf_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [127:0] all_outputs();
    return 128'({exe_valid, req_ready, done, busy, first, last, lane_mask, chunk_idx,
                 aluControl, useInmediate, useScalarAlu, isScalarReg2,
                 perf_beats, perf_stalls});
  endfunction

  // Reference model: beats an operation must produce, from the plain rules
  task automatic push_expected(input int vlen, input logic [3:0] alu,
                               input logic imm, input logic sc, input logic sr2);
    int    nb;
    int    rem;
    beat_t e;
    nb  = sc ? 1 : (vlen + VS - 1) / VS;
    rem = vlen % VS;
    for (int i = 0; i < nb; i++) begin
      e.alu   = alu;
      e.imm   = imm;
      e.sc    = sc;
      e.sr2   = sr2;
      e.idx   = IDX_W'(i);
      if (sc)                          e.mask = VS'(1);
      else if (i == nb - 1 && rem != 0) e.mask = VS'((1 << rem) - 1);
      else                              e.mask = {VS{1'b1}};
      e.first = (i == 0);
      e.last  = (i == nb - 1);
      exp_q.push_back(e);
    end
  endtask

  // exe_ready driver: random backpressure or a directed level
  initial begin
    exe_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      exe_ready = rand_en ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: compare beats on handshake, hold during stalls, done timing
  initial begin
    logic  done_due;
    logic  stall_prev;
    beat_t snap;
    beat_t cur;
    beat_t e;
    done_due   = 1'b0;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        done_due   = 1'b0;
        stall_prev = 1'b0;
        continue;
      end
      if (done || done_due) begin
        check("done_pulse", 128'(done), 128'(done_due));
        if (done_due && !flush) check("ready_with_done", 128'(req_ready), 128'(1));
      end
      done_due = 1'b0;
      cur = {aluControl, useInmediate, useScalarAlu, isScalarReg2, chunk_idx, lane_mask, first, last};
      if (stall_prev) begin
        check("stall_hold", 128'({exe_valid, cur}), 128'({1'b1, snap}));
      end
      stall_prev = 1'b0;
      if (exe_valid) begin
        check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
        if (exe_ready && exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat", 128'(cur), 128'(e));
          if (e.last && !flush) done_due = 1'b1;
        end else if (!exe_ready) begin
          snap       = cur;
          stall_prev = !flush;
        end
      end
      if (req_valid && req_ready && !req_useScalarAlu && req_vlen == '0) done_due = 1'b1;
    end
  end

  task automatic issue(input int vlen, input logic [3:0] alu,
                       input logic imm, input logic sc, input logic sr2);
    logic ok;
    int   nb;
    nb = sc ? 1 : (vlen + VS - 1) / VS;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_valid        = 1'b1;
    req_vlen         = LEN_W'(vlen);
    req_aluControl   = alu;
    req_useInmediate = imm;
    req_useScalarAlu = sc;
    req_isScalarReg2 = sr2;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        push_expected(vlen, alu, imm, sc, sr2);
        break;
      end
      @(posedge clk);
      #1;
    end
    check("req_accepted", 128'(ok), 128'(1));
    @(posedge clk);
    #1;
    req_valid        = 1'b0;
    req_vlen         = LEN_W'($urandom);
    req_aluControl   = 4'($urandom);
    req_useInmediate = 1'($urandom);
    req_useScalarAlu = 1'($urandom);
    req_isScalarReg2 = 1'($urandom);
    if (ok) begin
      @(negedge clk);
      check("first_beat_latency", 128'(exe_valid), 128'(nb != 0));
    end
  endtask

  task automatic wait_idle(input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 128'(ok), 128'(1));
    if (!ok) exp_q.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pb0;
    logic [31:0] ps0;
    int          v;
    rst_n            = 1'b0;
    flush            = 1'b0;
    req_valid        = 1'b0;
    req_vlen         = '0;
    req_aluControl   = '0;
    req_useInmediate = 1'b0;
    req_useScalarAlu = 1'b0;
    req_isScalarReg2 = 1'b0;
    rand_en          = 1'b0;
    ready_force      = 1'b1;

    @(negedge clk);
    check("reset_outputs", all_outputs(), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_reset", 128'(req_ready), 128'(1));

    issue(20, 4'h3, 1'b0, 1'b0, 1'b1);
    wait_idle(100);
    issue(16, 4'h5, 1'b1, 1'b0, 1'b0);
    wait_idle(100);
    issue(0, 4'h7, 1'b0, 1'b0, 1'b0);
    wait_idle(100);
    issue(37, 4'h9, 1'b1, 1'b1, 1'b1);
    wait_idle(100);

    // Three-cycle stall on beat 1 of a 3-beat op
    @(negedge clk);
    pb0 = perf_beats;
    ps0 = perf_stalls;
    issue(24, 4'hA, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    ready_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_force = 1'b1;
    wait_idle(100);
`ifdef VEXEC_SEQ_PERF_EN
    check("perf_beats_delta", 128'(perf_beats - pb0), 128'(3));
    check("perf_stalls_delta", 128'(perf_stalls - ps0), 128'(3));
`else
    check("perf_beats_off", 128'(perf_beats), 128'(0));
    check("perf_stalls_off", 128'(perf_stalls), 128'(0));
`endif

    // Flush during beat 1 with a competing request
    issue(24, 4'hC, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    flush            = 1'b1;
    req_valid        = 1'b1;
    req_vlen         = LEN_W'(8);
    req_useScalarAlu = 1'b0;
    @(negedge clk);
    check("flush_blocks_req", 128'(req_ready), 128'(0));
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_state", 128'({exe_valid, busy, req_ready}), 128'(3'b001));

    // Asynchronous reset in the middle of a 5-beat op
    issue(40, 4'h6, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_op_reset_outputs", all_outputs(), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    issue(8, 4'h2, 1'b0, 1'b0, 1'b0);
    wait_idle(100);

    // Randomized traffic with random backpressure, some back-to-back
    rand_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 9));
      else                           v = int'($urandom_range(0, 255));
      issue(v, 4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle(600);
    end
    wait_idle(600);
    rand_en = 1'b0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
